fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction fetch for the pipeline.
- Talks to instruction memory through a request/ready handshake, with a one-entry skid buffer for stalls.
- Applies redirects in priority order: exception entry, ERET, then ID-stage branch/jump.
- Computes branch/jump targets from the same NPCOP encoding used by the datapath, and delivers the IF/ID instruction bundle.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000, legal span in bytes; legal range is [IMEM_BASE, IMEM_BASE+IMEM_SIZE).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held with imem_addr stable until imem_ready
- imem_addr  out  32  fetch address
- imem_ready  in  1  response strobe; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched word
- if_stall  in  1  downstream holds the IF/ID bundle
- redirect_valid  in  1  ID-stage control transfer
- npc_op  in  4  0 NORMAL, 1 BRANCH, 2 JIMM, 3 JREG, others NORMAL
- redirect_pc  in  32  PC of the branch/jump instruction
- jump  in  32  offset / index / register value, per npc_op
- exc_req  in  1  take exception
- eret_req  in  1  return from exception
- epc  in  32  ERET target
- if_valid  out  1  IF/ID bundle valid
- if_pc  out  32  PC of the bundle
- if_instr  out  32  instruction of the bundle
- if_adel  out  1  bundle is a fetch address error

Behaviour:
- Reset (async, any state, including with a fetch outstanding):
  - pc=RESET_PC, state=BOOT, skid empty.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0, if_adel=0.
- States:
  - BOOT: one cycle, then FETCH.
  - FETCH: request outstanding.
  - FULL: skid occupied, no request.
  - DRAIN: discard an outstanding response.
  - HALT: illegal pc, fetching stopped until a redirect.
- Target calculation (32-bit, wrap-around, no overflow flag):
  - BRANCH: redirect_pc+4+{jump[29:0],2'b00}
  - JIMM: {redirect_pc[31:28],jump[25:0],2'b00}
  - JREG: jump
  - NORMAL/default: redirect_pc+4
  - exc target: EXC_VECTOR; eret target: epc.
- Redirect priority: exc_req > eret_req > redirect_valid. Only the winner acts in a cycle. Redirects are honoured regardless of if_stall.
- Illegal pc (pc[1:0]!=0 or outside range):
  - in FETCH, imem_req=0; no memory access is made.
  - Next edge: if_valid=1, if_adel=1, if_pc=pc, if_instr=0; state HALT.
- FETCH with legal pc:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with no redirect, if_stall=0 or if_valid=0: load if_* from rdata, if_adel=0, pc+=4; stay in FETCH.
  - On imem_ready with if_stall=1 and if_valid=1: write word+pc into the skid, pc+=4, go to FULL.
- FULL: imem_req=0. When if_stall=0: move skid to if_*, skid empty, go to FETCH.
- if_stall=1 with no skid write: if_* hold; never more than one fetched-but-undelivered instruction.
- Exception or ERET:
  - Next edge: if_valid=0, skid cleared, pc=target.
  - If a request is outstanding and imem_ready=0: go to DRAIN. imem_req stays high on the old address until ready, the response is dropped, then FETCH.
  - If ready is asserted the same cycle: drop the response, go to FETCH.
- Branch redirect (delay slot preserved):
  - The instruction at redirect_pc+4 is kept wherever it is (if_*, skid, or arriving this cycle).
  - Anything at any other address is discarded.
  - pc=target; same DRAIN rule applies to non-delay-slot outstanding requests.
  - If the delay slot is itself outstanding at redirect time, its response is delivered, then fetch continues at target; the target is latched internally.
- A redirect in DRAIN updates the latched target (latest winner applies).
- Exception in HALT leaves HALT.

Decomposition:
- Shared package: NPCOP codes (NORMAL/BRANCH/JIMM/JREG), RESET_PC, EXC_VECTOR, IMEM_BASE/IMEM_SIZE, state encoding.
- One combinational sub-module, npc_target_calc: npc_op, redirect_pc, jump -> target.
- Everything else (FSM, skid, pc register, pending target) lives in fetch_sequencer.

Test Plan:
- Reset release, imem_ready tied 1 -> imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; if_valid=1 with if_pc=0x3000 one cycle after the first ready.
- if_stall=1 for 3 cycles while if_pc=0x3004 -> if_* hold; exactly one more fetch (0x3008) goes to the skid; imem_req=0; after release if_pc=0x3008, then 0x300C.
- redirect_valid, npc_op=1, redirect_pc=0x3010, jump=0x4 -> 0x3014 delivered; next imem_addr=0x3024, nothing else delivered.
- exc_req while a fetch of 0x3020 waits (imem_ready low 3 cycles) -> imem_req held on 0x3020 until ready; data dropped; if_valid=0; next imem_addr=0x4180. exc_req+eret_req together -> 0x4180.
- npc_op=3, jump=0x3002 -> no imem_req at 0x3002; if_adel=1, if_pc=0x3002, if_instr=0; state HALT until exc_req.
- reset_n low during DRAIN -> immediate reset values; after release first imem_addr=0x3000, stale response ignored.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, NPCOP codes, state encoding and slot type for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_SIZE  = 32'h0000_4000;

    localparam logic [3:0] NPC_NORMAL = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_JIMM   = 4'd2;
    localparam logic [3:0] NPC_JREG   = 4'd3;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StFull,
        StDrain,
        StHalt
    } fetch_state_e;

    // One fetched-but-undelivered instruction (IF/ID bundle or skid entry).
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_slot_t;

    // Word aligned and inside [IMEM_BASE, IMEM_BASE+IMEM_SIZE); the subtraction wraps
    // addresses below the base to large values so one compare covers both bounds.
    function automatic logic pc_is_legal(input logic [31:0] pc);
        logic [31:0] offset;
        offset = pc - IMEM_BASE;
        return (pc[1:0] == 2'b00) && (offset < IMEM_SIZE);
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Branch/jump target calculation from the datapath NPCOP encoding.
module npc_target_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [3:0]  npc_op_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] jump_i,
    output logic [31:0] target_o
);

    logic [31:0] seq_pc;

    assign seq_pc = redirect_pc_i + 32'd4;

    // Select the target; unknown op codes fall through as sequential.
    always_comb begin
        target_o = seq_pc;
        case (npc_op_i)
            NPC_BRANCH: target_o = seq_pc + {jump_i[29:0], 2'b00};
            NPC_JIMM:   target_o = {redirect_pc_i[31:28], jump_i[25:0], 2'b00};
            NPC_JREG:   target_o = jump_i;
            default:    target_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: imem handshake, one-entry skid, prioritised redirects, IF/ID bundle.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [3:0]  npc_op,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] jump,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_addr_q, hold_addr_d;  // address of the request being drained
    logic         keep_q, keep_d;            // drained response is a delay slot to deliver
    fetch_slot_t  if_q, if_d;
    fetch_slot_t  skid_q, skid_d;

    logic [31:0]  br_target, ds_pc, redir_target;
    logic         take_br, any_redir, kill_all;
    logic         pc_legal, fetching, outstanding, slot_free;
    fetch_slot_t  arr, held, skid_s;

    npc_target_calc u_npc_target_calc (
        .npc_op_i      (npc_op),
        .redirect_pc_i (redirect_pc),
        .jump_i        (jump),
        .target_o      (br_target)
    );

    assign kill_all     = exc_req | eret_req;
    assign take_br      = redirect_valid & ~kill_all;
    assign any_redir    = kill_all | redirect_valid;
    assign ds_pc        = redirect_pc + 32'd4;
    assign redir_target = exc_req ? EXC_VECTOR : (eret_req ? epc : br_target);

    assign pc_legal    = pc_is_legal(pc_q);
    assign fetching    = (state_q == StFetch) && pc_legal;
    assign imem_req    = fetching || (state_q == StDrain);
    assign imem_addr   = (state_q == StDrain) ? hold_addr_q : pc_q;
    assign outstanding = imem_req && !imem_ready;
    assign slot_free   = !(if_q.valid && if_stall);

    assign if_valid = if_q.valid;
    assign if_pc    = if_q.pc;
    assign if_instr = if_q.instr;
    assign if_adel  = if_q.adel;

    // Filter the held bundle, skid and arrival through the redirect, then pack them
    // in program order into IF/ID and skid; also compute pc and next state.
    always_comb begin
        arr = '0;
        if (imem_ready && (fetching || (state_q == StDrain && keep_q))) begin
            arr = '{valid: 1'b1, pc: imem_addr, instr: imem_rdata, adel: 1'b0};
        end else if (state_q == StFetch && !pc_legal && slot_free && !any_redir) begin
            arr = '{valid: 1'b1, pc: pc_q, instr: 32'd0, adel: 1'b1};
        end
        arr.valid = arr.valid && !kill_all && (!take_br || arr.pc == ds_pc);

        held        = if_q;
        held.valid  = if_q.valid && if_stall && !kill_all && (!take_br || if_q.pc == ds_pc);
        skid_s       = skid_q;
        skid_s.valid = skid_q.valid && !kill_all && (!take_br || skid_q.pc == ds_pc);

        if_d         = if_q;
        if_d.valid   = 1'b0;
        skid_d       = skid_q;
        skid_d.valid = 1'b0;
        if (held.valid) begin
            if_d   = held;
            skid_d = skid_s.valid ? skid_s : arr;
        end else if (skid_s.valid) begin
            if_d   = skid_s;
            skid_d = arr;
        end else if (arr.valid) begin
            if_d = arr;
        end

        pc_d        = pc_q;
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        keep_d      = keep_q;
        if (any_redir) begin
            pc_d = redir_target;
            if (outstanding) begin
                state_d     = StDrain;
                hold_addr_d = imem_addr;
                keep_d      = take_br && (imem_addr == ds_pc) && (fetching || keep_q);
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StBoot:  state_d = StFetch;
                StFetch: begin
                    if (fetching && imem_ready) begin
                        pc_d = pc_q + 32'd4;
                    end else if (arr.valid && arr.adel) begin
                        state_d = StHalt;
                    end
                end
                StDrain: if (imem_ready) state_d = StFetch;
                default: ;
            endcase
        end
        if (skid_d.valid) begin
            state_d = StFull;
        end else if (state_q == StFull && !any_redir) begin
            state_d = StFetch;
        end
    end

    // State, pc, drain bookkeeping and bundle registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
            keep_q      <= 1'b0;
            if_q        <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            keep_q      <= keep_d;
            if_q        <= if_d;
            skid_q      <= skid_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [3:0]  npc_op = 4'd0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] jump = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .npc_op         (npc_op),
        .redirect_pc    (redirect_pc),
        .jump           (jump),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_adel        (if_adel)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          adel;
    } ent_t;

    ent_t        q[$];      // q[0] is the visible bundle, q[1] the skid
    logic [31:0] m_pc;
    logic [31:0] m_hold;
    bit          m_boot, m_halt, m_drain, m_keep;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit m_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a < 32'h0000_7000);
    endfunction

    function automatic logic [31:0] m_target(input logic [3:0] op, input logic [31:0] rpc,
                                             input logic [31:0] j);
        case (op)
            4'd1:    return rpc + 32'd4 + (j << 2);
            4'd2:    return {rpc[31:28], j[25:0], 2'b00};
            4'd3:    return j;
            default: return rpc + 32'd4;
        endcase
    endfunction

    function automatic bit m_req();
        if (m_boot) return 1'b0;
        if (m_drain) return 1'b1;
        if (m_halt || q.size() >= 2) return 1'b0;
        return m_legal(m_pc);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drain ? m_hold : m_pc;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0000_3000;
        m_hold  = 32'h0000_3000;
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_drain = 1'b0;
        m_keep  = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit          req, arr, deliv, adel, br, outst, any;
        logic [31:0] addr, ds;
        ent_t        e;
        ent_t        nq[$];
        req   = m_req();
        addr  = m_addr();
        arr   = req && imem_ready;
        deliv = arr && (!m_drain || m_keep);
        any   = exc_req || eret_req || redirect_valid;
        adel  = !m_boot && !m_halt && !m_drain && !m_legal(m_pc) && !any &&
                (q.size() == 0 || (q.size() == 1 && !if_stall));
        if (q.size() > 0 && !if_stall) void'(q.pop_front());
        if (any) begin
            br = !exc_req && !eret_req;
            ds = redirect_pc + 32'd4;
            nq = {};
            if (br) begin
                foreach (q[i]) if (q[i].pc == ds) nq.push_back(q[i]);
                if (deliv && addr == ds) begin
                    e.pc = addr; e.instr = imem_rdata; e.adel = 1'b0;
                    nq.push_back(e);
                end
            end
            q = nq;
            outst   = req && !imem_ready;
            m_keep  = outst && br && (addr == ds) && (!m_drain || m_keep);
            m_drain = outst;
            if (outst) m_hold = addr;
            m_pc   = exc_req ? 32'h0000_4180 :
                     (eret_req ? epc : m_target(npc_op, redirect_pc, jump));
            m_boot = 1'b0;
            m_halt = 1'b0;
        end else begin
            if (deliv) begin
                e.pc = addr; e.instr = imem_rdata; e.adel = 1'b0;
                q.push_back(e);
            end
            if (arr && !m_drain) m_pc = m_pc + 32'd4;
            if (m_drain && imem_ready) m_drain = 1'b0;
            if (adel) begin
                e.pc = m_pc; e.instr = 32'd0; e.adel = 1'b1;
                q.push_back(e);
                m_halt = 1'b1;
            end
            m_boot = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("model imem_req", {31'd0, imem_req}, {31'd0, m_req()});
            if (m_req()) check("model imem_addr", imem_addr, m_addr());
            check("model if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("model if_pc", if_pc, q[0].pc);
                check("model if_instr", if_instr, q[0].instr);
                check("model if_adel", {31'd0, if_adel}, {31'd0, q[0].adel});
            end
        end
    end

    task automatic next_cycle();
        imem_rdata = mem_word(m_addr());
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst imem_req", {31'd0, imem_req}, 32'd0);
        check("rst imem_addr", imem_addr, 32'h0000_3000);
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst if_pc", if_pc, 32'd0);
        check("rst if_instr", if_instr, 32'd0);
        check("rst if_adel", {31'd0, if_adel}, 32'd0);
    endtask

    int sel;

    initial begin
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk); #1;
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        check("boot no req", {31'd0, imem_req}, 32'd0);

        // Streaming with ready tied high.
        next_cycle();
        check("first addr", imem_addr, 32'h3000);
        check("first req", {31'd0, imem_req}, 32'd1);
        next_cycle();
        check("second addr", imem_addr, 32'h3004);
        check("first bundle pc", if_pc, 32'h3000);
        check("first bundle instr", if_instr, mem_word(32'h3000));
        next_cycle();
        check("third addr", imem_addr, 32'h3008);
        check("bundle 3004", if_pc, 32'h3004);

        // Stall: 0x3008 lands in the skid, fetching stops.
        if_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("stall hold pc", if_pc, 32'h3004);
            check("stall no req", {31'd0, imem_req}, 32'd0);
        end
        if_stall = 1'b0;
        next_cycle();
        check("skid out pc", if_pc, 32'h3008);
        check("after skid addr", imem_addr, 32'h300C);
        next_cycle();
        check("after skid pc", if_pc, 32'h300C);
        next_cycle();
        check("bundle 3010", if_pc, 32'h3010);

        // Branch at 0x3010: delay slot 0x3014 arrives and is kept, target 0x3024.
        redirect_valid = 1'b1; npc_op = 4'd1; redirect_pc = 32'h3010; jump = 32'h4;
        next_cycle();
        redirect_valid = 1'b0;
        check("delay slot pc", if_pc, 32'h3014);
        check("delay slot valid", {31'd0, if_valid}, 32'd1);
        check("branch target addr", imem_addr, 32'h3024);
        imem_ready = 1'b0;
        next_cycle();
        check("nothing after slot", {31'd0, if_valid}, 32'd0);

        // JREG to 0x3020, then exception while that fetch is pending.
        redirect_valid = 1'b1; npc_op = 4'd3; redirect_pc = 32'h3100; jump = 32'h3020;
        imem_ready = 1'b1;
        next_cycle();
        redirect_valid = 1'b0;
        check("jreg addr", imem_addr, 32'h3020);
        exc_req = 1'b1; imem_ready = 1'b0;
        next_cycle();
        exc_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain req", {31'd0, imem_req}, 32'd1);
            check("drain addr", imem_addr, 32'h3020);
            check("drain no bundle", {31'd0, if_valid}, 32'd0);
            next_cycle();
        end
        imem_ready = 1'b1;
        next_cycle();
        check("exc vector addr", imem_addr, 32'h4180);
        check("drained dropped", {31'd0, if_valid}, 32'd0);
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3500;
        next_cycle();
        exc_req = 1'b0; eret_req = 1'b0;
        check("exc beats eret", imem_addr, 32'h4180);

        // Misaligned JREG target: address error bundle, then halt.
        redirect_valid = 1'b1; npc_op = 4'd3; jump = 32'h3002;
        next_cycle();
        redirect_valid = 1'b0;
        check("illegal no req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        check("adel valid", {31'd0, if_valid}, 32'd1);
        check("adel flag", {31'd0, if_adel}, 32'd1);
        check("adel pc", if_pc, 32'h3002);
        check("adel instr", if_instr, 32'd0);
        next_cycle();
        check("halt no req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        check("halt still", {31'd0, imem_req}, 32'd0);
        exc_req = 1'b1;
        next_cycle();
        exc_req = 1'b0;
        check("halt exit addr", imem_addr, 32'h4180);

        // Asynchronous reset while draining.
        exc_req = 1'b1; imem_ready = 1'b0;
        next_cycle();
        exc_req = 1'b0;
        check("pre-reset drain", {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk); #1;
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        next_cycle();
        check("post-reset addr", imem_addr, 32'h3000);
        next_cycle();
        check("post-reset pc", if_pc, 32'h3000);
        check("post-reset instr", if_instr, mem_word(32'h3000));

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            if_stall       = ($urandom_range(0, 3) == 0);
            imem_ready     = ($urandom_range(0, 9) < 7);
            exc_req        = ($urandom_range(0, 49) == 0);
            eret_req       = ($urandom_range(0, 49) == 0);
            epc            = 32'h3000 + ($urandom_range(0, 255) << 2);
            redirect_valid = ($urandom_range(0, 9) == 0);
            npc_op         = 4'($urandom_range(0, 5));
            sel            = int'($urandom_range(0, 3));
            if (sel == 0 && q.size() > 0) redirect_pc = q[0].pc - 32'd4;
            else if (sel == 1 && q.size() > 0) redirect_pc = q[0].pc;
            else if (sel == 2) redirect_pc = m_addr() - 32'd4;
            else redirect_pc = 32'h3000 + ($urandom_range(0, 1023) << 2);
            case (npc_op)
                4'd1: jump = $urandom_range(0, 64) - 32'd32;
                4'd2: jump = 32'h0C00 + $urandom_range(0, 1023);
                4'd3: jump = ($urandom_range(0, 9) == 0) ? 32'h3002 :
                             (32'h3000 + ($urandom_range(0, 1023) << 2));
                default: jump = $urandom;
            endcase
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
